// File: rtl/reg_a_pipe_pkg.sv
// Shared helpers for the reg_a_pipe elastic register chain.
package reg_a_pipe_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned cw_of(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_a_stage.sv
// One valid-tagged data register of the reg_a_pipe chain.
module reg_a_stage #(
   parameter int unsigned      WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic             CLEAR,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] D,
   output logic             V,
   output logic [WIDTH-1:0] Q
);

   logic             v_q;
   logic [WIDTH-1:0] d_q;

   // Valid bit: flush wins, then a load fills the slot, else an advance-out empties it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v_q <= 1'b0;
      end else if (FLUSH) begin
         v_q <= 1'b0;
      end else if (LOAD) begin
         v_q <= 1'b1;
      end else if (CLEAR) begin
         v_q <= 1'b0;
      end
   end

   // Data only moves on a real load, so empty slots never toggle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         d_q <= INIT;
      end else if (LOAD && !FLUSH) begin
         d_q <= D;
      end
   end

   assign V = v_q;
   assign Q = d_q;

endmodule

// File: rtl/reg_a_pipe.sv
// DEPTH-stage elastic pipeline register with collapsing bubbles, flush and occupancy count.
module reg_a_pipe
   import reg_a_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH = 1,
   parameter int unsigned      DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0,
   localparam int unsigned     CW    = cw_of(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENQ,
   input  logic [WIDTH-1:0] D_IN,
   output logic             RDY_ENQ,
   input  logic             DEQ,
   output logic [WIDTH-1:0] Q_OUT,
   output logic             VALID,
   input  logic             FLUSH,
   output logic [CW-1:0]    COUNT
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] d [DEPTH];
   logic             rdy;
   logic             enq_acc;
   logic             deq_acc;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // Advance chain, resolved from the output end: a slot is free if empty or emptying.
   always_comb begin
      logic f;
      logic a;
      adv = '0;
      f   = DEQ;
      a   = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         a      = v[i] & f;
         adv[i] = a;
         f      = ~v[i] | a;
      end
      rdy = f;
   end

   assign enq_acc = ENQ & rdy & ~FLUSH;
   assign deq_acc = v[DEPTH-1] & DEQ;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             load;
      logic [WIDTH-1:0] din;
      if (i == 0) begin : g_head
         assign load = enq_acc;
         assign din  = D_IN;
      end else begin : g_body
         assign load = adv[i-1];
         assign din  = d[i-1];
      end
      reg_a_stage #(
         .WIDTH(WIDTH),
         .INIT (INIT)
      ) u_stage (
         .CLK  (CLK),
         .RST  (RST),
         .LOAD (load),
         .CLEAR(adv[i]),
         .FLUSH(FLUSH),
         .D    (din),
         .V    (v[i]),
         .Q    (d[i])
      );
   end

   // Occupancy next-state: only a lone enq or a lone deq changes it.
   always_comb begin
      count_d = count_q;
      if (FLUSH) begin
         count_d = '0;
      end else if (enq_acc && !deq_acc) begin
         count_d = count_q + CW'(1);
      end else if (!enq_acc && deq_acc) begin
         count_d = count_q - CW'(1);
      end
   end

   // Occupancy register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign RDY_ENQ = rdy;
   assign Q_OUT   = d[DEPTH-1];
   assign VALID   = v[DEPTH-1];
   assign COUNT   = count_q;

endmodule

// File: tb/tb_reg_a_pipe.sv
// Scoreboard bench for reg_a_pipe: item/position model drives expectations, monitor checks output.
module tb_reg_a_pipe;

   localparam int D = 3;
   localparam logic [7:0] INITV = 8'hA5;

   logic       CLK = 1'b0;
   logic       RST;
   logic       enq, deq, flush;
   logic [7:0] din;
   logic       rdy, valid;
   logic [7:0] q;
   logic [1:0] count;

   logic       enq1, deq1;
   logic       flush1 = 1'b0;
   logic [7:0] din1;
   logic       rdy1, valid1;
   logic [7:0] q1;
   logic [0:0] count1;

   always #5 CLK = ~CLK;

   reg_a_pipe #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) dut (
      .CLK(CLK), .RST(RST), .ENQ(enq), .D_IN(din), .RDY_ENQ(rdy), .DEQ(deq),
      .Q_OUT(q), .VALID(valid), .FLUSH(flush), .COUNT(count)
   );

   reg_a_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'hA5)) dut1 (
      .CLK(CLK), .RST(RST), .ENQ(enq1), .D_IN(din1), .RDY_ENQ(rdy1), .DEQ(deq1),
      .Q_OUT(q1), .VALID(valid1), .FLUSH(flush1), .COUNT(count1)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every item in flight with its stage index; items advance one stage per
   // cycle but can never reach or pass the slot the item ahead of them ends up in.
   typedef struct {
      logic [7:0] d;
      int         pos;
   } item_t;

   item_t      m[$];
   logic [7:0] sb[$];
   int         np_a[16];

   logic exp_rdy, exp_valid;
   int   exp_count;
   logic mon_en = 1'b0;

   // Fills np_a with next positions (D means delivered); returns whether slot 0 is free.
   function automatic logic model_calc(input logic dq);
      int lim;
      lim = D;
      for (int k = 0; k < m.size(); k++) begin
         if (k == 0 && m[0].pos == D - 1 && dq) np_a[k] = D;
         else np_a[k] = (m[k].pos + 1 < lim - 1) ? m[k].pos + 1 : lim - 1;
         lim = np_a[k];
      end
      return (m.size() == 0) || (np_a[m.size()-1] > 0);
   endfunction

   function automatic void model_step(input logic acc, input logic [7:0] dv, input logic dq,
                                      input logic fl);
      item_t nq[$];
      logic  r;
      if (fl) begin
         m.delete();
         return;
      end
      r = model_calc(dq);
      for (int k = 0; k < m.size(); k++) begin
         if (np_a[k] < D) begin
            item_t it;
            it = m[k];
            it.pos = np_a[k];
            nq.push_back(it);
         end
      end
      if (acc) begin
         item_t it;
         it.d = dv;
         it.pos = 0;
         nq.push_back(it);
      end
      m = nq;
   endfunction

   // One cycle of stimulus; entered and left 1 time unit after a rising edge.
   task automatic drive(input logic e, input logic [7:0] dv, input logic dq, input logic fl);
      logic acc;
      enq = e; din = dv; deq = dq; flush = fl;
      exp_rdy   = model_calc(dq);
      exp_valid = (m.size() > 0) && (m[0].pos == D - 1);
      exp_count = m.size();
      acc = e & exp_rdy & ~fl;
      if (acc) sb.push_back(dv);
      @(posedge CLK);
      #1;
      model_step(acc, dv, dq, fl);
   endtask

   // Monitor: handshake-level checks plus in-order data delivery from the scoreboard.
   always @(negedge CLK) begin
      logic [7:0] e;
      if (mon_en && !RST) begin
         check("rdy_enq", 32'(rdy), 32'(exp_rdy));
         check("valid", 32'(valid), 32'(exp_valid));
         check("count", 32'(count), 32'(exp_count));
         if (valid && deq) begin
            if (sb.size() == 0) begin
               check("deliver_unexpected", 32'(q), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("q_out", 32'(q), 32'(e));
            end
         end
         if (flush) sb.delete();
      end
   end

   initial begin
      RST = 1'b1;
      enq = 0; deq = 0; flush = 0; din = 0;
      enq1 = 0; deq1 = 0; din1 = 0;
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_q", 32'(q), 32'(INITV));
      check("rst_count", 32'(count), 32'd0);
      check("rst_rdy", 32'(rdy), 32'd1);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // DEPTH=1 variant.
      enq1 = 1; din1 = 8'h40; deq1 = 0;
      #1 check("d1_rdy_empty", 32'(rdy1), 32'd1);
      @(posedge CLK);
      #1 enq1 = 0;
      check("d1_valid", 32'(valid1), 32'd1);
      check("d1_q40", 32'(q1), 32'h40);
      check("d1_count", 32'(count1), 32'd1);
      check("d1_rdy_full", 32'(rdy1), 32'd0);
      enq1 = 1; din1 = 8'h41; deq1 = 1;
      #1 check("d1_rdy_deq", 32'(rdy1), 32'd1);
      @(posedge CLK);
      #1 enq1 = 0; deq1 = 0;
      check("d1_q41", 32'(q1), 32'h41);
      check("d1_valid2", 32'(valid1), 32'd1);
      check("d1_count2", 32'(count1), 32'd1);

      mon_en = 1'b1;
      // Streaming.
      for (int v = 1; v <= 6; v++) drive(1, 8'(v), 1, 0);
      repeat (4) drive(0, 8'h00, 1, 0);
      // Back-pressure, then simultaneous enq+deq while full.
      drive(1, 8'h10, 0, 0);
      drive(1, 8'h11, 0, 0);
      drive(1, 8'h12, 0, 0);
      repeat (3) drive(1, 8'h13, 0, 0);
      drive(1, 8'h13, 1, 0);
      repeat (5) drive(0, 8'h00, 1, 0);
      // Bubble collapse.
      drive(1, 8'h20, 0, 0);
      drive(0, 8'h00, 0, 0);
      drive(1, 8'h21, 0, 0);
      repeat (3) drive(0, 8'h00, 0, 0);
      repeat (3) drive(0, 8'h00, 1, 0);
      // Flush with simultaneous enq and deq.
      drive(1, 8'h50, 0, 0);
      drive(1, 8'h51, 0, 0);
      repeat (2) drive(0, 8'h00, 0, 0);
      drive(1, 8'h30, 1, 1);
      repeat (4) drive(0, 8'h00, 1, 0);

      // Asynchronous reset mid-cycle with two items held.
      drive(1, 8'h60, 0, 0);
      drive(1, 8'h61, 0, 0);
      mon_en = 1'b0;
      enq = 1; din = 8'h62; deq = 1; flush = 0;
      #2 RST = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_q", 32'(q), 32'(INITV));
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_rdy", 32'(rdy), 32'd1);
      m.delete();
      sb.delete();
      @(posedge CLK);
      #1;
      check("rst_hold_valid", 32'(valid), 32'd0);
      check("rst_hold_count", 32'(count), 32'd0);
      enq = 0; deq = 0;
      #2 RST = 1'b0;
      @(posedge CLK);
      #1;
      mon_en = 1'b1;

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
      end
      repeat (6) drive(0, 8'h00, 1, 0);
      check("drain_count", 32'(count), 32'(sb.size()));
      check("drain_valid", 32'(valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_a_pipe.md
Name: reg_a_pipe

Overview:
- Parametrised successor to the single async-reset enable register: a DEPTH-stage, WIDTH-bit elastic pipeline register chain.
- Each stage carries a valid bit, so data advances only into free slots. Bubbles collapse under back-pressure, and the chain can be flushed.
- Sits between producer/consumer blocks that need retiming or fixed delay while still honouring ready/enable handshakes.

Parameters:
- WIDTH, 1, data bits per stage.
- DEPTH, 2, number of register stages; legal range 1..16.
- INIT, all zeros (WIDTH bits), data value loaded into every stage on reset.
- CW, clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  reset, asynchronous and active-high.
- ENQ  in  1  producer offers D_IN this cycle.
- D_IN  in  WIDTH  enqueue data.
- RDY_ENQ  out  1  stage 0 can accept this cycle.
- DEQ  in  1  consumer takes Q_OUT this cycle.
- Q_OUT  out  WIDTH  data of last stage (DEPTH-1).
- VALID  out  1  last stage holds valid data.
- FLUSH  in  1  synchronous clear of all valid bits.
- COUNT  out  CW  number of valid stages.

Behaviour:
- Reset (RST=1, asynchronous, takes effect immediately, also mid-operation):
  - all valid bits = 0 and all stage data = INIT.
  - Q_OUT=INIT, VALID=0, COUNT=0, RDY_ENQ=1.
  - ENQ, DEQ and FLUSH are ignored while RST=1.
- Stage i (0..DEPTH-1) holds v[i] and d[i]. The last stage drives Q_OUT/VALID.
- Advance rule, computed combinationally from the output end:
  - adv[DEPTH-1] = v[DEPTH-1] & DEQ.
  - For i<DEPTH-1: free[i+1] = !v[i+1] | adv[i+1], and adv[i] = v[i] & free[i+1].
  - RDY_ENQ = !v[0] | adv[0].
  - RDY_ENQ therefore depends combinationally on DEQ; this path is documented and accepted.
- On posedge, stage i+1 loads d[i] when adv[i] (v[i+1] <= 1). Otherwise v[i+1] clears if adv[i+1], else holds.
- Stage 0 loads D_IN when ENQ & RDY_ENQ.
- ENQ while RDY_ENQ=0: no effect, data dropped. The producer must hold ENQ.
- DEQ while VALID=0: no effect.
- Data of a stage not being loaded holds its value; invalid stages do not toggle.
- Latency: with no back-pressure, D_IN enqueued at cycle t appears at Q_OUT with VALID=1 at cycle t+DEPTH.
- Throughput: 1 item/cycle.
- Back-pressure: with DEQ=0, items collapse toward the output. After DEPTH accepted items, RDY_ENQ=0. Ordering is always preserved (FIFO).
- Full with DEQ=1: RDY_ENQ=1 in the same cycle, so a simultaneous enq+deq keeps COUNT unchanged.
- COUNT is registered, updated each posedge:
  - +1 on accepted enq only.
  - -1 on accepted deq only.
  - unchanged when both or neither occur.
  - Never exceeds DEPTH; never wraps.
- FLUSH=1 on a posedge:
  - All v[] clear next cycle and COUNT=0.
  - A simultaneous ENQ is discarded even if RDY_ENQ=1.
  - A simultaneous DEQ with VALID=1 still counts as delivered to the consumer.
  - Data registers are not reset by FLUSH.
- DEPTH=1 degenerates to a single valid-tagged register with RDY_ENQ = !VALID | DEQ.

Decomposition:
- Shared package: clog2 helper function and the CW derivation.
- One natural sub-module: reg_a_stage (WIDTH-bit data register plus valid bit, async active-high reset to INIT/0, load/clear/flush inputs), instantiated DEPTH times by a generate loop.
- Advance/ready logic and COUNT stay in reg_a_pipe.

Test Plan (WIDTH=8, DEPTH=3, INIT=8'hA5 unless noted):
- Reset: assert RST mid-cycle with 2 items held → immediately VALID=0, Q_OUT=8'hA5, COUNT=0, RDY_ENQ=1, without waiting for a clock edge.
- Streaming: enq 8'h01..8'h06 on consecutive cycles with DEQ=1 → 8'h01 at Q_OUT/VALID 3 cycles after its enq, then one item per cycle in order; COUNT saturates at 3.
- Back-pressure: DEQ=0, enq 8'h10, 8'h11, 8'h12, 8'h13 → after 3 accepts RDY_ENQ=0 and COUNT=3; 8'h13 is held off. Raise DEQ → 8'h10 delivered and 8'h13 accepted in the same cycle; COUNT stays 3.
- Bubble collapse: enq 8'h20, idle 1 cycle, enq 8'h21 with DEQ=0 → both reach stages 2 and 1 adjacent; later DEQ delivers 8'h20 then 8'h21 on consecutive cycles.
- Flush: with COUNT=2, assert FLUSH together with ENQ=1 (D_IN=8'h30) and DEQ=1 → next cycle COUNT=0 and VALID=0; 8'h30 never appears at Q_OUT.
- DEPTH=1 build: enq 8'h40 → VALID=1 next cycle. Hold DEQ=0 → RDY_ENQ=0. DEQ=1 with ENQ 8'h41 → 8'h41 at Q_OUT next cycle.
